// File: rtl/nn_pkg.sv
// Shared definitions for the neuron weight sequencer: controller state encoding
// and the width of the layer/neuron index fields on the broadcast config bus.
package nn_pkg;

    localparam int CFG_IDX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } nn_state_e;

endpackage

// File: rtl/seq_cnt.sv
// Wrapping up-counter with enable: counts 0..MAX, then wraps to 0.
// tc_o flags the terminal value MAX so the caller can act on the wrapping step.
module seq_cnt #(
    parameter int WIDTH = 10,
    parameter int MAX   = 783
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign tc_o  = (cnt_q == WIDTH'(MAX));
    assign cnt_d = tc_o ? '0 : cnt_q + WIDTH'(1);
    assign cnt_o = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/neuron_weight_seq.sv
// Per-neuron weight controller: loads weights from the config bus and pairs each
// input sample with its weight for the MAC. WEIGHT_PRETRAINED_EN selects ROM weights.
module neuron_weight_seq #(
    parameter int NUM_WEIGHT    = 784,
    parameter int NEURON_NUMBER = 0,
    parameter int LAYER_NUMBER  = 1,
    parameter int ADDRESS_WIDTH = 10,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [31:0]              cfg_layer,
    input  logic [31:0]              cfg_neuron,
    input  logic [DATA_WIDTH-1:0]    cfg_data,
    input  logic                     x_valid,
    output logic                     x_ready,
    input  logic [DATA_WIDTH-1:0]    x_data,
    output logic                     mem_wen,
    output logic [ADDRESS_WIDTH-1:0] mem_wadd,
    output logic [DATA_WIDTH-1:0]    mem_win,
    output logic                     mem_ren,
    output logic [ADDRESS_WIDTH-1:0] mem_radd,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic                     mac_valid,
    output logic [DATA_WIDTH-1:0]    mac_x,
    output logic [DATA_WIDTH-1:0]    mac_w,
    output logic                     mac_last,
    output logic                     loaded
);

    import nn_pkg::*;

    nn_state_e state_q;
    logic      loaded_q;

    logic hit_acc;
    logic x_acc;
    logic wcnt_tc;

    logic [ADDRESS_WIDTH-1:0] rcnt;
    logic                     rcnt_tc;

    logic                     mem_ren_q;
    logic [ADDRESS_WIDTH-1:0] mem_radd_q;
    logic [DATA_WIDTH-1:0]    x_dly_q;
    logic                     ren_last_q;
    logic                     mac_valid_q;
    logic [DATA_WIDTH-1:0]    mac_x_q;
    logic                     mac_last_q;

`ifdef WEIGHT_PRETRAINED_EN
    localparam logic LOADED_RST = 1'b1;

    wire unused_cfg = ^{cfg_valid, cfg_layer, cfg_neuron, cfg_data};

    assign cfg_ready = 1'b0;
    assign hit_acc   = 1'b0;
    assign wcnt_tc   = 1'b0;
    assign mem_wen   = 1'b0;
    assign mem_wadd  = '0;
    assign mem_win   = '0;
`else
    localparam logic LOADED_RST = 1'b0;

    logic                     cfg_hit;
    logic [ADDRESS_WIDTH-1:0] wcnt;
    logic                     mem_wen_q;
    logic [ADDRESS_WIDTH-1:0] mem_wadd_q;
    logic [DATA_WIDTH-1:0]    mem_win_q;

    assign cfg_hit = cfg_valid
                   & (cfg_layer  == CFG_IDX_WIDTH'(LAYER_NUMBER))
                   & (cfg_neuron == CFG_IDX_WIDTH'(NEURON_NUMBER));

    // A waiting input sample outranks config once weights are present.
    assign cfg_ready = (state_q == LOAD) ||
                       ((state_q == IDLE) && !(loaded_q && x_valid));
    assign hit_acc   = cfg_hit & cfg_ready;

    seq_cnt #(
        .WIDTH (ADDRESS_WIDTH),
        .MAX   (NUM_WEIGHT - 1)
    ) u_wcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (hit_acc),
        .cnt_o (wcnt),
        .tc_o  (wcnt_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wen_q  <= 1'b0;
            mem_wadd_q <= '0;
            mem_win_q  <= '0;
        end else begin
            mem_wen_q <= hit_acc;
            if (hit_acc) begin
                mem_wadd_q <= wcnt;
                mem_win_q  <= cfg_data;
            end
        end
    end

    assign mem_wen  = mem_wen_q;
    assign mem_wadd = mem_wadd_q;
    assign mem_win  = mem_win_q;
`endif

    assign x_ready = ((state_q == IDLE) && loaded_q) || (state_q == RUN);
    assign x_acc   = x_valid & x_ready;

    seq_cnt #(
        .WIDTH (ADDRESS_WIDTH),
        .MAX   (NUM_WEIGHT - 1)
    ) u_rcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (x_acc),
        .cnt_o (rcnt),
        .tc_o  (rcnt_tc)
    );

    // Read pipeline: accept -> mem_ren (stage 1) -> mac_valid with memory data (stage 2).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            loaded_q    <= LOADED_RST;
            mem_ren_q   <= 1'b0;
            mem_radd_q  <= '0;
            x_dly_q     <= '0;
            ren_last_q  <= 1'b0;
            mac_valid_q <= 1'b0;
            mac_x_q     <= '0;
            mac_last_q  <= 1'b0;
        end else begin
            mem_ren_q   <= x_acc;
            ren_last_q  <= x_acc & rcnt_tc;
            mac_valid_q <= mem_ren_q;
            mac_last_q  <= mem_ren_q & ren_last_q;
            if (x_acc) begin
                mem_radd_q <= rcnt;
                x_dly_q    <= x_data;
            end
            if (mem_ren_q) begin
                mac_x_q <= x_dly_q;
            end

            case (state_q)
                IDLE: begin
                    if (x_acc) begin
                        state_q <= RUN;
                    end else if (hit_acc) begin
                        state_q  <= LOAD;
                        loaded_q <= 1'b0;
                    end
                end
                LOAD: begin
                    if (hit_acc && wcnt_tc) begin
                        state_q  <= IDLE;
                        loaded_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (x_acc && rcnt_tc) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_ren   = mem_ren_q;
    assign mem_radd  = mem_radd_q;
    assign mac_valid = mac_valid_q;
    assign mac_x     = mac_x_q;
    assign mac_w     = mem_rdata;
    assign mac_last  = mac_last_q;
    assign loaded    = loaded_q;

endmodule

// File: tb/tb_neuron_weight_seq.sv
// Self-checking bench for neuron_weight_seq (default RAM build): table-driven
// config/sample vectors, a memory model, and write/MAC scoreboards.
module tb_neuron_weight_seq;

    localparam int NW = 4;
    localparam int NN = 2;
    localparam int LN = 1;
    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [31:0]   cfg_layer = '0;
    logic [31:0]   cfg_neuron = '0;
    logic [DW-1:0] cfg_data = '0;
    logic          x_valid = 1'b0;
    logic          x_ready;
    logic [DW-1:0] x_data = '0;
    logic          mem_wen;
    logic [AW-1:0] mem_wadd;
    logic [DW-1:0] mem_win;
    logic          mem_ren;
    logic [AW-1:0] mem_radd;
    logic [DW-1:0] mem_rdata = '0;
    logic          mac_valid;
    logic [DW-1:0] mac_x;
    logic [DW-1:0] mac_w;
    logic          mac_last;
    logic          loaded;

    neuron_weight_seq #(
        .NUM_WEIGHT    (NW),
        .NEURON_NUMBER (NN),
        .LAYER_NUMBER  (LN),
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_layer  (cfg_layer),
        .cfg_neuron (cfg_neuron),
        .cfg_data   (cfg_data),
        .x_valid    (x_valid),
        .x_ready    (x_ready),
        .x_data     (x_data),
        .mem_wen    (mem_wen),
        .mem_wadd   (mem_wadd),
        .mem_win    (mem_win),
        .mem_ren    (mem_ren),
        .mem_radd   (mem_radd),
        .mem_rdata  (mem_rdata),
        .mac_valid  (mac_valid),
        .mac_x      (mac_x),
        .mac_w      (mac_w),
        .mac_last   (mac_last),
        .loaded     (loaded)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: one write port, one registered read port.
    logic [DW-1:0] memArr [16];
    always @(posedge clk) begin
        if (mem_wen) memArr[mem_wadd] <= mem_win;
        if (mem_ren) mem_rdata <= memArr[mem_radd];
    end

    typedef struct {
        logic [31:0]   layer;
        logic [31:0]   neuron;
        logic [DW-1:0] data;
        bit            hit;
    } cfgVec_t;

    typedef struct {
        logic [DW-1:0] x;
        int            wIdx;
        bit            gapAfter;
    } xVec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } wrExp_t;

    typedef struct {
        logic [DW-1:0] x;
        logic [DW-1:0] w;
        logic          last;
        int            cyc;
    } macExp_t;

    wrExp_t  wrQ[$];
    macExp_t macQ[$];
    wrExp_t  wE;
    macExp_t mE;

    cfgVec_t       loadTab[7];
    cfgVec_t       reloadTab[3];
    xVec_t         xTab[8];
    logic [DW-1:0] wExp[NW];
    int            wIdxNext = 0;

    int nTests = 0;
    int nFails = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wen && mem_ren) checkOutput("wen_ren_exclusive", 32'd1, 32'd0);
            if (mem_wen) begin
                if (wrQ.size() == 0) begin
                    checkOutput("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wE = wrQ.pop_front();
                    checkOutput("mem_wadd", 32'(mem_wadd), 32'(wE.addr));
                    checkOutput("mem_win", 32'(mem_win), 32'(wE.data));
                    checkOutput("write_cycle", 32'(cyc), 32'(wE.cyc));
                end
            end
            if (mac_valid) begin
                if (macQ.size() == 0) begin
                    checkOutput("unexpected_mac", 32'd1, 32'd0);
                end else begin
                    mE = macQ.pop_front();
                    checkOutput("mac_x", 32'(mac_x), 32'(mE.x));
                    checkOutput("mac_w", 32'(mac_w), 32'(mE.w));
                    checkOutput("mac_last", 32'(mac_last), 32'(mE.last));
                    checkOutput("mac_cycle", 32'(cyc), 32'(mE.cyc));
                end
            end
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_mem_wen"}, 32'(mem_wen), 32'd0);
        checkOutput({tag, "_mem_ren"}, 32'(mem_ren), 32'd0);
        checkOutput({tag, "_mem_wadd"}, 32'(mem_wadd), 32'd0);
        checkOutput({tag, "_mem_radd"}, 32'(mem_radd), 32'd0);
        checkOutput({tag, "_mem_win"}, 32'(mem_win), 32'd0);
        checkOutput({tag, "_mac_valid"}, 32'(mac_valid), 32'd0);
        checkOutput({tag, "_mac_x"}, 32'(mac_x), 32'd0);
        checkOutput({tag, "_mac_last"}, 32'(mac_last), 32'd0);
        checkOutput({tag, "_loaded"}, 32'(loaded), 32'd0);
    endtask

    // One config word in IDLE/LOAD: must be accepted, and any held sample must stall.
    task automatic applyStimulus(input cfgVec_t v, input bit finalHit);
        cfg_valid  = 1'b1;
        cfg_layer  = v.layer;
        cfg_neuron = v.neuron;
        cfg_data   = v.data;
        @(negedge clk);
        checkOutput("cfg_ready_load", 32'(cfg_ready), 32'd1);
        checkOutput("x_ready_load", 32'(x_ready), 32'd0);
        checkOutput("loaded_during_load", 32'(loaded), 32'd0);
        if (v.hit) begin
            wrQ.push_back('{addr: AW'(wIdxNext), data: v.data, cyc: cyc + 1});
            wIdxNext = (wIdxNext + 1) % NW;
        end
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        if (finalHit) begin
            checkOutput("loaded_with_final_write", 32'(loaded), 32'd1);
            checkOutput("wen_with_final_write", 32'(mem_wen), 32'd1);
        end
    endtask

    task automatic sendX(input logic [DW-1:0] xv, input logic [DW-1:0] wv, input logic lastv,
                         input bit cfgBlocked);
        int budget = 0;
        x_valid = 1'b1;
        x_data  = xv;
        @(negedge clk);
        while (!x_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!x_ready) begin
            checkOutput("x_accept_timeout", 32'd0, 32'd1);
        end else begin
            if (cfgBlocked) checkOutput("cfg_ready_blocked", 32'(cfg_ready), 32'd0);
            macQ.push_back('{x: xv, w: wv, last: lastv, cyc: cyc + 2});
        end
        @(posedge clk);
        #1;
        x_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int budget = 0;
        while ((macQ.size() != 0 || wrQ.size() != 0) && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        checkOutput("drain_timeout", 32'(macQ.size() + wrQ.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic runPasses(input int first, input int count, input bit cfgBlocked);
        for (int i = first; i < first + count; i++) begin
            sendX(xTab[i].x, wExp[xTab[i].wIdx], logic'(xTab[i].wIdx == NW - 1), cfgBlocked);
            if (xTab[i].gapAfter) begin
                @(posedge clk);
                #1;
            end
            if (xTab[i].wIdx == NW - 1) begin
                @(negedge clk);
                checkOutput("x_ready_drain", 32'(x_ready), 32'd0);
                if (cfgBlocked) checkOutput("cfg_ready_drain", 32'(cfg_ready), 32'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        loadTab[0] = '{layer: LN, neuron: NN,     data: 16'h0011, hit: 1'b1};
        loadTab[1] = '{layer: LN, neuron: NN + 1, data: 16'h0055, hit: 1'b0};
        loadTab[2] = '{layer: LN, neuron: NN,     data: 16'h0012, hit: 1'b1};
        loadTab[3] = '{layer: LN + 1, neuron: NN, data: 16'h0066, hit: 1'b0};
        loadTab[4] = '{layer: LN, neuron: NN,     data: 16'h0013, hit: 1'b1};
        loadTab[5] = '{layer: LN, neuron: NN + 1, data: 16'h0077, hit: 1'b0};
        loadTab[6] = '{layer: LN, neuron: NN,     data: 16'h0014, hit: 1'b1};
        reloadTab[0] = '{layer: LN, neuron: NN, data: 16'h0021, hit: 1'b1};
        reloadTab[1] = '{layer: LN, neuron: NN, data: 16'h0022, hit: 1'b1};
        reloadTab[2] = '{layer: LN, neuron: NN, data: 16'h0023, hit: 1'b1};
        for (int i = 0; i < 8; i++) begin
            xTab[i] = '{x: DW'(i % NW + 1), wIdx: i % NW, gapAfter: (i == 5)};
        end
        wExp[0] = 16'h0011;
        wExp[1] = 16'h0012;
        wExp[2] = 16'h0013;
        wExp[3] = 16'h0014;

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkResetOutputs("reset");
        checkOutput("reset_cfg_ready", 32'(cfg_ready), 32'd1);
        checkOutput("reset_x_ready", 32'(x_ready), 32'd0);
        @(posedge clk);
        #1;

        // Load with a sample held: while unloaded, config wins and the sample stalls.
        x_valid = 1'b1;
        x_data  = 16'h00AA;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(loadTab[i], (i == 6));
        end
        x_valid = 1'b0;
        @(negedge clk);
        checkOutput("idle_x_ready", 32'(x_ready), 32'd1);
        checkOutput("idle_cfg_ready", 32'(cfg_ready), 32'd1);
        @(posedge clk);
        #1;
        waitDrain();

        // Two passes: back-to-back, the second with a gap after its 2nd sample.
        runPasses(0, 8, 1'b0);
        waitDrain();

        // Loaded + config pending: samples win until the pass ends, then the reload starts.
        cfg_valid  = 1'b1;
        cfg_layer  = LN;
        cfg_neuron = NN;
        cfg_data   = 16'h0099;
        runPasses(0, 4, 1'b1);
        @(negedge clk);
        checkOutput("cfg_ready_after_drain", 32'(cfg_ready), 32'd1);
        checkOutput("x_ready_after_drain", 32'(x_ready), 32'd1);
        wrQ.push_back('{addr: AW'(wIdxNext), data: 16'h0099, cyc: cyc + 1});
        wIdxNext = (wIdxNext + 1) % NW;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        checkOutput("loaded_cleared_on_reload", 32'(loaded), 32'd0);
        x_valid = 1'b1;
        x_data  = 16'h00BB;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(reloadTab[i], (i == 2));
        end
        x_valid = 1'b0;
        wExp[0] = 16'h0099;
        wExp[1] = 16'h0021;
        wExp[2] = 16'h0022;
        wExp[3] = 16'h0023;
        waitDrain();
        for (int i = 0; i < NW; i++) begin
            sendX(DW'(i + 5), wExp[i], logic'(i == NW - 1), 1'b0);
        end
        waitDrain();

        // Asynchronous reset in the middle of a pass.
        sendX(16'h0031, wExp[0], 1'b0, 1'b0);
        sendX(16'h0032, wExp[1], 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("async_reset");
        macQ.delete();
        wrQ.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        x_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("x_ready_after_reset", 32'(x_ready), 32'd0);
        end
        x_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        checkOutput("wr_queue_empty", 32'(wrQ.size()), 32'd0);
        checkOutput("mac_queue_empty", 32'(macQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end

endmodule

// File: doc/neuron_weight_seq.md
Name: neuron_weight_seq

Overview:
- Per-neuron controller that owns one weight memory instance (1 write port, 1 read port, 1-cycle registered read).
- Loads weights from the broadcast config bus.
- Sequences one weight read per accepted input sample.
- Presents aligned (x, w) pairs to the neuron MAC, with a last flag on the final pair of each pass.
- Sits between the layer input stream and the neuron MAC; one instance per neuron.

Parameters:
- NUM_WEIGHT, 784, weights per neuron (inputs per pass); must be >= 2.
- NEURON_NUMBER, 0, this neuron's index; matched against cfg_neuron.
- LAYER_NUMBER, 1, this layer's index; matched against cfg_layer.
- ADDRESS_WIDTH, 10, memory address width; 2^ADDRESS_WIDTH >= NUM_WEIGHT.
- DATA_WIDTH, 16, weight and input sample width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  config word present.
- cfg_ready  out  1  config word accepted this cycle when cfg_valid & cfg_ready.
- cfg_layer  in  32  target layer index.
- cfg_neuron  in  32  target neuron index.
- cfg_data  in  DATA_WIDTH  weight value.
- x_valid  in  1  input sample present.
- x_ready  out  1  sample accepted when x_valid & x_ready.
- x_data  in  DATA_WIDTH  input sample.
- mem_wen  out  1  memory write enable.
- mem_wadd  out  ADDRESS_WIDTH  memory write address.
- mem_win  out  DATA_WIDTH  memory write data.
- mem_ren  out  1  memory read enable.
- mem_radd  out  ADDRESS_WIDTH  memory read address.
- mem_rdata  in  DATA_WIDTH  memory read data, valid 1 cycle after mem_ren.
- mac_valid  out  1  aligned pair valid.
- mac_x  out  DATA_WIDTH  input sample.
- mac_w  out  DATA_WIDTH  weight; equals mem_rdata, combinational pass-through.
- mac_last  out  1  final pair of the pass, qualified by mac_valid.
- loaded  out  1  all NUM_WEIGHT weights present.

Behaviour:
- Reset values: state=IDLE, counters 0, loaded=0.
- All outputs at reset are 0: mem_wen, mem_ren, mem_wadd, mem_radd, mem_win, mac_valid, mac_x, mac_last. mac_w follows mem_rdata.
- Reset is legal in any state. It aborts loading or a pass immediately; partial memory contents are not cleared but loaded=0.
- States: IDLE, LOAD, RUN, DRAIN.
- Config match: hit = cfg_valid & (cfg_layer==LAYER_NUMBER) & (cfg_neuron==NEURON_NUMBER).
- cfg_ready=1 in IDLE and LOAD, except in IDLE when loaded & x_valid (input has priority); cfg_ready=0 in RUN and DRAIN.
- Non-matching accepted words are consumed silently with no write.
- Accepted hit: registered write next cycle. mem_wen=1, mem_wadd=wcnt, mem_win=cfg_data.
- wcnt increments on each accepted hit and wraps NUM_WEIGHT-1 -> 0.
- IDLE -> LOAD on first accepted hit; loaded is cleared on that hit (reload).
- LOAD -> IDLE on the hit with wcnt==NUM_WEIGHT-1; loaded=1 in the same cycle as that final mem_wen.
- x_ready=1 only in IDLE with loaded=1, or in RUN. x_ready=0 in LOAD, DRAIN, and whenever loaded=0.
- IDLE -> RUN on an accepted sample.
- Each accepted sample: registered mem_ren=1, mem_radd=rcnt; x_data captured to a 1-deep delay register.
- Next cycle after mem_ren: mac_valid=1, mac_x=delayed sample, mac_w=mem_rdata. Latency from x accept to mac_valid is 2 cycles.
- rcnt increments per accepted sample.
- On the accept with rcnt==NUM_WEIGHT-1: rcnt -> 0 and state -> DRAIN.
- DRAIN lasts 1 cycle: the final mac_valid with mac_last=1, then IDLE.
- Back-to-back passes: DRAIN forces one bubble; a pass is at least NUM_WEIGHT+1 cycles.
- x_valid gaps in RUN stall the sequence. No pair is emitted for a gap; rcnt holds.
- Simultaneous cfg_valid & x_valid in IDLE:
  - loaded=1: x accepted, cfg stalled.
  - loaded=0: cfg accepted, x stalled.
- mem_wen and mem_ren are never asserted in the same cycle.

Optional Feature:
- Macro WEIGHT_PRETRAINED_EN.
- Defined: memory is ROM-initialised. loaded resets to 1, cfg_ready is constant 0, LOAD is unreachable, and mem_wen/mem_wadd/mem_win are constant 0.
- Undefined: RAM behaviour as above.

Decomposition:
- Shared package nn_pkg: state encoding enum (IDLE, LOAD, RUN, DRAIN) and the config field width constant CFG_IDX_WIDTH=32.
- Sub-module seq_cnt: wrapping counter with enable, terminal-count flag and parameter MAX. Instantiated twice, for wcnt and rcnt.

Test Plan:
- Load NUM_WEIGHT=4 words 0x11..0x14 to matching layer/neuron -> mem_wen at addr 0..3 with those data; loaded rises with the 4th write; state returns to IDLE.
- Interleave non-matching cfg words (cfg_neuron=NEURON_NUMBER+1) -> cfg_ready=1, no mem_wen, wcnt unchanged.
- After load, stream x=1,2,3,4 back-to-back with the memory model returning the stored weights -> mac pairs (1,0x11)..(4,0x14), each 2 cycles after its accept; mac_last only on the 4th.
- x_valid with a 1-cycle gap after the 2nd sample -> mac_valid gap of 1 cycle; pairs unchanged.
- cfg_valid and x_valid together in IDLE: with loaded=1 -> x wins and cfg_ready=0 until DRAIN->IDLE; with loaded=0 -> cfg wins and x_ready=0.
- Assert rst_n=0 mid-RUN after 2 samples -> all outputs 0 asynchronously, loaded=0; after release x_ready=0 until a reload (with WEIGHT_PRETRAINED_EN: loaded=1, x_ready=1 immediately).
